pwm_capture: RTL and testbench

- Capture-side counterpart of the PWM generator channel. It measures an incoming PWM waveform and reports high time and period in ClkIn cycles.
- Intended uses: loop-back check of PWM outputs, and decoding external PWM sensors and servo commands.
- Input is asynchronous and is synchronised internally.
- Results are published once per PWM period with a one-cycle Valid strobe. Loss of edges is flagged by a timeout.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_edge_sync.sv | 45 ++++
 rtl/pwm_capture.sv | 173 +++++++++++++++++
 tb/tb_pwm_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator and capture blocks: the default
// PWM resolution (so that generator and capture agree on period length),
// the capture state encoding, and a helper that gives the all-ones value
// of a counter of a given width.
// No ports.
// ---------------------------------------------------------------------------
package pwm_pkg;

    // Resolution of the PWM channel in bits; a full period is 2^RESOLUTION.
    localparam int DEFAULT_RESOLUTION = 10;

    // Capture state machine encoding.
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwmState_t;

    // Largest value a counter of 'width' bits can hold; used as the
    // timeout threshold of the capture counters.
    function automatic int unsigned cntMax(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// ---------------------------------------------------------------------------
// pwm_edge_sync
// Brings an asynchronous input into the clock domain through three flops
// and reports single-cycle rise/fall events on the synchronised signal.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset, clears all three flops
//   i_async  asynchronous input
//   o_level  synchronised level (second flop)
//   o_rise   synchronised level went 0 -> 1 this cycle
//   o_fall   synchronised level went 1 -> 0 this cycle
// ---------------------------------------------------------------------------
module pwm_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // The first two flops are the metastability filter; the third holds the
    // previous synchronised value so edges can be detected without adding
    // further latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an incoming PWM waveform: high time and period, in clock cycles,
// between consecutive synchronised rising edges. A result is published with
// a one-cycle valid strobe on each rise after the first. If no edge arrives
// before the period counter reaches its maximum, a sticky timeout is raised
// and the static input level is latched (0 % or 100 % duty).
// Ports:
//   i_clkIn     system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_en        capture enable; low holds results and returns to SYNC
//   i_pwmIn     asynchronous PWM input
//   o_tonMeas   last measured high time
//   o_tperMeas  last measured period
//   o_valid     one-cycle strobe, results just updated
//   o_timeout   no edge seen within the counter range; cleared by o_valid
//   o_level     input level latched at the last timeout
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    parameter int CNT_WIDTH  = RESOLUTION + 1
) (
    input  logic                 i_clkIn,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_pwmIn,
    output logic [CNT_WIDTH-1:0] o_tonMeas,
    output logic [CNT_WIDTH-1:0] o_tperMeas,
    output logic                 o_valid,
    output logic                 o_timeout,
    output logic                 o_level
);

    localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = CNT_WIDTH'(cntMax(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] L_CNT_ONE = CNT_WIDTH'(1);

    logic                 w_level;
    logic                 w_rise;
    logic                 w_fall;

    pwmState_t            r_state;
    logic [CNT_WIDTH-1:0] r_hiCnt;
    logic [CNT_WIDTH-1:0] r_perCnt;
    logic [CNT_WIDTH-1:0] r_tonMeas;
    logic [CNT_WIDTH-1:0] r_tperMeas;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 r_level;

    pwmState_t            w_nextState;
    logic [CNT_WIDTH-1:0] w_hiNext;
    logic [CNT_WIDTH-1:0] w_perNext;
    logic [CNT_WIDTH-1:0] w_hiInc;
    logic [CNT_WIDTH-1:0] w_perInc;
    logic                 w_perAtMax;
    logic                 w_publish;
    logic                 w_timeoutHit;

    pwm_edge_sync u_edgeSync (
        .i_clk   (i_clkIn),
        .i_rst   (i_rst),
        .i_async (i_pwmIn),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Saturating increments: a fall that lands exactly on the maximum count
    // must not wrap the period counter; the LOW state then times out on the
    // following cycle instead.
    assign w_perAtMax = (r_perCnt == L_CNT_MAX);
    assign w_perInc   = w_perAtMax ? r_perCnt : r_perCnt + L_CNT_ONE;
    assign w_hiInc    = (r_hiCnt == L_CNT_MAX) ? r_hiCnt : r_hiCnt + L_CNT_ONE;

    // Next-state and counter logic. Both counters start at 1 on a rise so
    // the rise cycle itself is counted. A rise on the cycle the period
    // counter reaches its maximum is still a valid measurement and wins over
    // the timeout.
    always_comb begin
        w_nextState  = r_state;
        w_hiNext     = r_hiCnt;
        w_perNext    = r_perCnt;
        w_publish    = 1'b0;
        w_timeoutHit = 1'b0;
        if (!i_en) begin
            w_nextState = SYNC;
            w_hiNext    = '0;
            w_perNext   = '0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_rise) begin
                        w_nextState = HIGH;
                        w_hiNext    = L_CNT_ONE;
                        w_perNext   = L_CNT_ONE;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_nextState = LOW;
                        w_perNext   = w_perInc;
                    end else if (w_perAtMax) begin
                        w_timeoutHit = 1'b1;
                        w_nextState  = SYNC;
                        w_hiNext     = '0;
                        w_perNext    = '0;
                    end else begin
                        w_hiNext  = w_hiInc;
                        w_perNext = w_perInc;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_publish   = 1'b1;
                        w_nextState = HIGH;
                        w_hiNext    = L_CNT_ONE;
                        w_perNext   = L_CNT_ONE;
                    end else if (w_perAtMax) begin
                        w_timeoutHit = 1'b1;
                        w_nextState  = SYNC;
                        w_hiNext     = '0;
                        w_perNext    = '0;
                    end else begin
                        w_perNext = w_perInc;
                    end
                end
                default: begin
                    w_nextState = SYNC;
                    w_hiNext    = '0;
                    w_perNext   = '0;
                end
            endcase
        end
    end

    // State, counters and published results. Results, timeout and level
    // only change on a publish or a timeout, so they naturally hold while
    // capture is disabled.
    always_ff @(posedge i_clkIn) begin
        if (i_rst) begin
            r_state    <= SYNC;
            r_hiCnt    <= '0;
            r_perCnt   <= '0;
            r_tonMeas  <= '0;
            r_tperMeas <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_level    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_hiCnt  <= w_hiNext;
            r_perCnt <= w_perNext;
            r_valid  <= w_publish;
            if (w_publish) begin
                r_tonMeas  <= r_hiCnt;
                r_tperMeas <= r_perCnt;
                r_timeout  <= 1'b0;
            end else if (w_timeoutHit) begin
                r_timeout <= 1'b1;
                r_level   <= w_level;
            end
        end
    end

    assign o_tonMeas  = r_tonMeas;
    assign o_tperMeas = r_tperMeas;
    assign o_valid    = r_valid;
    assign o_timeout  = r_timeout;
    assign o_level    = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Drives PWM patterns into pwm_capture and compares every output on every
// cycle against a timestamp-based model of the measurement rules, plus a
// set of hand-computed expectations at known points.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CW   = 11;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          pwm;
    logic [CW-1:0] tonMeas;
    logic [CW-1:0] tperMeas;
    logic          valid;
    logic          timeout;
    logic          level;

    int nChecks;
    int nFails;

    // Model state: a three-deep delay line for the synchronised input, and
    // cycle timestamps of the last synchronised rise and fall.
    int  cyc;
    bit  mReady;
    bit  d1, d2, d3, s2, s3;
    bit  armed, sawFall;
    int  riseCyc, fallCyc, el;
    int  eTon, eTper;
    bit  eValid, eTimeout, eLevel;

    pwm_capture dut (
        .i_clkIn    (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_pwmIn    (pwm),
        .o_tonMeas  (tonMeas),
        .o_tperMeas (tperMeas),
        .o_valid    (valid),
        .o_timeout  (timeout),
        .o_level    (level)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a result is the distance between consecutive
    // synchronised rises, the high time is the distance from rise to fall,
    // and a timeout fires once the rise is MAXC cycles old with no edge.
    always @(posedge clk) begin
        if (rst) begin
            d1 = 0; d2 = 0; d3 = 0;
            armed = 0; sawFall = 0;
            eTon = 0; eTper = 0;
            eValid = 0; eTimeout = 0; eLevel = 0;
            mReady = 1;
        end else begin
            s2 = d2;
            s3 = d3;
            eValid = 0;
            if (!en) begin
                armed = 0;
            end else if (!armed) begin
                if (s2 && !s3) begin
                    armed = 1; riseCyc = cyc; sawFall = 0;
                end
            end else begin
                el = cyc - riseCyc;
                if (s2 && !s3) begin
                    eTper    = (el > MAXC) ? MAXC : el;
                    eTon     = sawFall ? (fallCyc - riseCyc) : eTper;
                    eValid   = 1;
                    eTimeout = 0;
                    riseCyc  = cyc;
                    sawFall  = 0;
                end else if (!s2 && s3) begin
                    sawFall = 1; fallCyc = cyc;
                end else if (el >= MAXC) begin
                    eTimeout = 1; eLevel = s2; armed = 0;
                end
            end
            d3 = d2; d2 = d1; d1 = pwm;
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mReady) begin
            checkOutput("valid",    32'(valid),    32'(eValid));
            checkOutput("timeout",  32'(timeout),  32'(eTimeout));
            checkOutput("level",    32'(level),    32'(eLevel));
            checkOutput("tonMeas",  32'(tonMeas),  eTon);
            checkOutput("tperMeas", 32'(tperMeas), eTper);
        end
    end

    task automatic holdLevel(input bit val, input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            pwm = val;
        end
    endtask

    task automatic applyStimulus(input int hi, input int lo, input int n);
        repeat (n) begin
            holdLevel(1'b1, hi);
            holdLevel(1'b0, lo);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic checkLiteral(input string tag, input int ton, input int tper,
                                input bit tmo);
        #1;
        checkOutput({tag, ".ton"},     32'(tonMeas),  ton);
        checkOutput({tag, ".tper"},    32'(tperMeas), tper);
        checkOutput({tag, ".timeout"}, 32'(timeout),  32'(tmo));
    endtask

    // Scenario sequence: loop-back duties, extremes, static levels, recovery,
    // period at the counter limit, reset and enable behaviour, then random
    // patterns.
    initial begin
        nChecks = 0; nFails = 0; cyc = 0; mReady = 0;
        rst = 1'b1; en = 1'b0; pwm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.valid", 32'(valid), 0);
        checkOutput("rst.level", 32'(level), 0);
        checkLiteral("rst", 0, 0, 0);
        rst = 1'b0; en = 1'b1;

        applyStimulus(256, 768, 3);
        checkLiteral("duty256", 256, 1024, 0);
        applyStimulus(1, 1023, 3);
        checkLiteral("duty1", 1, 1024, 0);
        applyStimulus(1023, 1, 3);
        checkLiteral("duty1023", 1023, 1024, 0);

        holdLevel(1'b0, 2100);
        checkLiteral("duty0", 1023, 1024, 1);
        checkOutput("duty0.level", 32'(level), 0);

        applyStimulus(10, 30, 1);
        checkOutput("recover1.timeout", 32'(timeout), 1);
        applyStimulus(10, 30, 1);
        checkLiteral("recover2", 10, 40, 0);

        holdLevel(1'b1, 2100);
        checkLiteral("duty100", 10, 40, 1);
        checkOutput("duty100.level", 32'(level), 1);

        applyStimulus(1000, 1047, 3);
        checkLiteral("perMax", 1000, 2047, 0);
        applyStimulus(1000, 1048, 2);
        checkLiteral("perOver", 1000, 2047, 1);
        checkOutput("perOver.level", 32'(level), 0);

        applyStimulus(20, 30, 2);
        holdLevel(1'b1, 5);
        pulseReset();
        #1;
        checkOutput("midRst.valid", 32'(valid), 0);
        checkOutput("midRst.level", 32'(level), 0);
        checkLiteral("midRst", 0, 0, 0);
        applyStimulus(20, 30, 3);
        checkLiteral("afterRst", 20, 50, 0);

        en = 1'b0;
        repeat (100) holdLevel(1'($urandom_range(0, 1)), 1);
        checkLiteral("disabled", 20, 50, 0);
        holdLevel(1'b0, 5);
        en = 1'b1;
        applyStimulus(15, 25, 3);
        checkLiteral("reEnable", 15, 40, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) pulseReset();
            if ($urandom_range(0, 7) == 0) begin
                en = 1'b0;
                holdLevel(1'($urandom_range(0, 1)), $urandom_range(1, 20));
                en = 1'b1;
            end
            applyStimulus($urandom_range(1, 300), $urandom_range(1, 300),
                          $urandom_range(1, 3));
        end
        holdLevel(1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
